simon_serial_ctrl: RTL
======================

Name: simon_serial_ctrl

Overview:
Host-side sequencer for the bit-serial Simon 32/64 encryption core. Accepts a parallel plaintext and key through a valid/ready handshake, then serialises the key and plaintext into the core's data_in/data_rdy load interface. It starts the run and collects the core's serial ciphertext into a parallel word, returned through a valid/ready handshake. Sits between the bus/host wrapper and the Simon core; it is the only driver of the core's data_in and data_rdy.

Parameters:
BLOCK_W, 32, block width in bits (plaintext/ciphertext)
KEY_W, 64, key width in bits
MAX_RUN_CYCLES, 1024, RUN-state watchdog limit in cycles before error abort

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
pt_in  input  BLOCK_W  plaintext word, sampled on input handshake
key_in  input  KEY_W  key word, sampled on input handshake
in_valid  input  1  host offers pt_in/key_in
in_ready  output  1  controller accepts a job (IDLE only)
ct_out  output  BLOCK_W  ciphertext word
out_valid  output  1  ct_out valid; held until accepted
out_ready  input  1  host consumes ct_out
core_data_in  output  1  serial bit to core
core_data_rdy  output  2  core command: 00 idle, 01 load plaintext bit, 10 load key bit, 11 run
core_cipher_out  input  1  serial ciphertext bit from core
core_valid  input  1  core presents one ciphertext bit this cycle
busy  output  1  high in any state other than IDLE
err  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (reset==0 at clk edge) applies in any state, including mid-job. Results: state=IDLE, in_ready=1, out_valid=0, ct_out=0, core_data_rdy=00, core_data_in=0, busy=0, err=0. All counters and shift registers cleared.
- FSM states: IDLE, LOAD_KEY, LOAD_PT, RUN, CAPTURE, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch key_in into key_sr and pt_in into pt_sr, then go to LOAD_KEY.
- LOAD_KEY: exactly KEY_W cycles.
  - core_data_rdy=10, core_data_in=key_sr[0], shift right each cycle (LSB first).
  - Bit counter runs 0..KEY_W-1; on KEY_W-1 go to LOAD_PT.
- LOAD_PT: exactly BLOCK_W cycles, same rules with pt_sr and core_data_rdy=01. Then go to RUN.
- RUN:
  - core_data_rdy=11 and the watchdog counter increments.
  - The first cycle with core_valid=1 goes to CAPTURE and that bit is captured in the same cycle.
  - If the watchdog reaches MAX_RUN_CYCLES with no core_valid: err=1 for one cycle, core_data_rdy=00, go to IDLE, no output.
- CAPTURE:
  - core_data_rdy stays 11.
  - Every cycle with core_valid=1: ct_sr <= {core_cipher_out, ct_sr[BLOCK_W-1:1]} (LSB arrives first), and the capture count increments.
  - Cycles with core_valid=0 are ignored (gaps permitted).
  - After BLOCK_W captured bits: ct_out <= ct_sr, out_valid=1, go to OUT. The bit captured in RUN counts as bit 0.
- OUT:
  - core_data_rdy=00, out_valid=1, ct_out stable.
  - On out_ready: out_valid drops the next cycle and the FSM goes to IDLE.
  - in_valid during OUT is not accepted (in_ready=0).
- Latency: in_valid accept -> first key bit is 1 cycle. Total load phase is KEY_W+BLOCK_W cycles (96 at defaults).
- core_valid in IDLE/LOAD/OUT is ignored.
- Counters: bit/capture counter width clog2(KEY_W)+1; watchdog width clog2(MAX_RUN_CYCLES)+1. Neither counter wraps; both are cleared on state entry.

Optional Feature:
Macro SIMON_CTRL_KEY_CACHE_EN.
- Enabled:
  - A KEY_W register holds the last fully loaded key, plus a key_cached flag set at the end of LOAD_KEY.
  - On accept, if key_cached and key_in equals the cached key, LOAD_KEY is skipped: IDLE -> LOAD_PT directly, saving KEY_W cycles.
  - The cache is invalidated by reset and by a watchdog abort.
- Disabled: the key is always loaded; no cache register is built.

Decomposition:
- Package simon_ctrl_pkg holds:
  - state enum
  - core_data_rdy codes (CMD_IDLE=2'b00, CMD_LOAD_PT=2'b01, CMD_LOAD_KEY=2'b10, CMD_RUN=2'b11)
  - default width constants
- One sub-module, simon_ctrl_shreg: a parametrised parallel-load, right-shift register with serial in/out. Instantiated for key_sr, pt_sr and ct_sr.

Test Plan:
- Known-answer test against the core model: key 64'h1918111009080100, pt 32'h65656877 -> ct_out 32'hc69be9bb, out_valid asserted. Check exactly 64 cycles of data_rdy=10, then 32 cycles of 01.
- Backpressure: hold out_ready=0 for 50 cycles -> out_valid and ct_out stay stable, in_ready=0. Then out_ready=1 -> IDLE next cycle, in_ready=1.
- Gapped capture: core_valid toggles 1,0,1,0 during output -> still exactly 32 bits captured; ct_out equals the known-answer value.
- Watchdog: core never asserts core_valid -> err pulses exactly at RUN cycle 1024, core_data_rdy=00, back in IDLE, out_valid never set.
- Reset mid-LOAD_PT (reset=0 at bit 10) -> next cycle core_data_rdy=00, in_ready=1. A fresh job afterwards produces the correct ciphertext.
- With SIMON_CTRL_KEY_CACHE_EN: two jobs with the same key -> the second job shows 0 cycles of data_rdy=10. Changing the key -> 64 load cycles again.

Source files
------------

// File: rtl/simon_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// simon_ctrl_pkg
// Shared definitions for the Simon 32/64 serial host controller:
//   - state_t   : controller FSM states
//   - CMD_*     : codes driven on the core's 2-bit data_rdy command bus
//   - DEF_*     : default widths and watchdog limit
// No ports (package).
// -----------------------------------------------------------------------------
package simon_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_KEY = 3'd1,
    ST_LOAD_PT  = 3'd2,
    ST_RUN      = 3'd3,
    ST_CAPTURE  = 3'd4,
    ST_OUT      = 3'd5
  } state_t;

  localparam logic [1:0] CMD_IDLE     = 2'b00;
  localparam logic [1:0] CMD_LOAD_PT  = 2'b01;
  localparam logic [1:0] CMD_LOAD_KEY = 2'b10;
  localparam logic [1:0] CMD_RUN      = 2'b11;

  localparam int DEF_BLOCK_W        = 32;
  localparam int DEF_KEY_W          = 64;
  localparam int DEF_MAX_RUN_CYCLES = 1024;

endpackage

// File: rtl/simon_ctrl_shreg.sv
// -----------------------------------------------------------------------------
// simon_ctrl_shreg
// Parallel-load, right-shift register with serial in/out. Bit 0 is the serial
// output; the serial input enters at the MSB, so data leaves LSB first.
// Load has priority over shift.
// Ports:
//   clk        : clock, rising edge
//   i_rst_n    : synchronous active-low reset, clears the register
//   i_load     : load i_load_val
//   i_load_val : parallel load value
//   i_shift    : shift right by one, i_ser_in into the MSB
//   i_ser_in   : serial input bit
//   o_par      : current parallel contents
//   o_ser      : current LSB (serial output)
// -----------------------------------------------------------------------------
module simon_ctrl_shreg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_shift,
  input  logic         i_ser_in,
  output logic [W-1:0] o_par,
  output logic         o_ser
);

  logic [W-1:0] r_data;
  logic [W-1:0] w_shifted;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      if (gi == W - 1) begin : g_msb
        assign w_shifted[gi] = i_ser_in;
      end else begin : g_low
        assign w_shifted[gi] = r_data[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_load_val;
    end else if (i_shift) begin
      r_data <= w_shifted;
    end
  end

  assign o_par = r_data;
  assign o_ser = r_data[0];

endmodule

// File: rtl/simon_serial_ctrl.sv
// -----------------------------------------------------------------------------
// simon_serial_ctrl
// Host-side sequencer for the bit-serial Simon 32/64 core. Takes a plaintext
// and key through a valid/ready handshake, streams the key (LSB first, cmd 10)
// then the plaintext (LSB first, cmd 01) into the core, issues run (cmd 11),
// gathers BLOCK_W serial ciphertext bits (LSB first, gaps allowed) and returns
// them through a valid/ready handshake. A watchdog aborts a run in which the
// core never answers.
//
// Optional feature, macro SIMON_CTRL_KEY_CACHE_EN: remembers the last fully
// loaded key; a job carrying the same key skips the key load phase.
//
// Ports:
//   clk             : clock, all logic on rising edge
//   reset           : synchronous active-low reset (0 = reset)
//   pt_in, key_in   : job operands, sampled on in_valid && in_ready
//   in_valid        : host offers a job
//   in_ready        : controller idle and accepting
//   ct_out          : ciphertext result
//   out_valid       : ct_out valid, held until out_ready
//   out_ready       : host takes ct_out
//   core_data_in    : serial load bit to core
//   core_data_rdy   : core command (00 idle, 01 pt bit, 10 key bit, 11 run)
//   core_cipher_out : serial ciphertext bit from core
//   core_valid      : core_cipher_out carries a bit this cycle
//   busy            : controller not idle
//   err             : one-cycle pulse after a watchdog abort
// -----------------------------------------------------------------------------
module simon_serial_ctrl
  import simon_ctrl_pkg::*;
#(
  parameter int BLOCK_W        = DEF_BLOCK_W,
  parameter int KEY_W          = DEF_KEY_W,
  parameter int MAX_RUN_CYCLES = DEF_MAX_RUN_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BLOCK_W-1:0] pt_in,
  input  logic [KEY_W-1:0]   key_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [BLOCK_W-1:0] ct_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               core_data_in,
  output logic [1:0]         core_data_rdy,
  input  logic               core_cipher_out,
  input  logic               core_valid,
  output logic               busy,
  output logic               err
);

  localparam int CNT_W = $clog2(KEY_W) + 1;
  localparam int WD_W  = $clog2(MAX_RUN_CYCLES) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0] PT_LAST  = CNT_W'(BLOCK_W - 1);
  localparam logic [CNT_W-1:0] CT_LAST  = CNT_W'(BLOCK_W - 1);
  localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(MAX_RUN_CYCLES - 1);

  state_t r_state;
  state_t w_state_next;

  logic [CNT_W-1:0]   r_cnt;
  logic [WD_W-1:0]    r_wd;
  logic [BLOCK_W-1:0] r_ct_out;
  logic               r_out_valid;
  logic               r_err;

  logic               w_accept;
  logic               w_key_hit;
  logic               w_cap_bit;
  logic               w_cap_done;
  logic               w_wd_abort;
  logic               w_state_change;
  logic               w_unused;

  logic [KEY_W-1:0]   w_key_par;
  logic               w_key_ser;
  logic [BLOCK_W-1:0] w_pt_par;
  logic               w_pt_ser;
  logic [BLOCK_W-1:0] w_ct_par;
  logic               w_ct_ser;

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  assign w_accept       = (r_state == ST_IDLE) && in_valid;
  // A bit is taken from the core in RUN (first bit) and in CAPTURE.
  assign w_cap_bit      = core_valid && ((r_state == ST_RUN) || (r_state == ST_CAPTURE));
  assign w_cap_done     = (r_state == ST_CAPTURE) && core_valid && (r_cnt == CT_LAST);
  // r_wd counts completed RUN cycles; WD_LAST means this is the final allowed one.
  assign w_wd_abort     = (r_state == ST_RUN) && !core_valid && (r_wd == WD_LAST);
  assign w_state_change = (w_state_next != r_state);

  // ---------------------------------------------------------------------------
  // Shift registers. The key register rotates rather than shifting in zeros so
  // that it holds the original key again once all KEY_W bits have gone out.
  // ---------------------------------------------------------------------------
  simon_ctrl_shreg #(.W(KEY_W)) u_key_sr (
    .clk        (clk),
    .i_rst_n    (reset),
    .i_load     (w_accept),
    .i_load_val (key_in),
    .i_shift    (r_state == ST_LOAD_KEY),
    .i_ser_in   (w_key_ser),
    .o_par      (w_key_par),
    .o_ser      (w_key_ser)
  );

  simon_ctrl_shreg #(.W(BLOCK_W)) u_pt_sr (
    .clk        (clk),
    .i_rst_n    (reset),
    .i_load     (w_accept),
    .i_load_val (pt_in),
    .i_shift    (r_state == ST_LOAD_PT),
    .i_ser_in   (1'b0),
    .o_par      (w_pt_par),
    .o_ser      (w_pt_ser)
  );

  // Cleared on accept so a new job never sees bits of the previous one.
  simon_ctrl_shreg #(.W(BLOCK_W)) u_ct_sr (
    .clk        (clk),
    .i_rst_n    (reset),
    .i_load     (w_accept),
    .i_load_val ({BLOCK_W{1'b0}}),
    .i_shift    (w_cap_bit),
    .i_ser_in   (core_cipher_out),
    .o_par      (w_ct_par),
    .o_ser      (w_ct_ser)
  );

  // ---------------------------------------------------------------------------
  // Optional key cache
  // ---------------------------------------------------------------------------
`ifdef SIMON_CTRL_KEY_CACHE_EN
  logic [KEY_W-1:0] r_key_cache;
  logic             r_key_cached;

  assign w_key_hit = r_key_cached && (key_in == r_key_cache);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_key_cache  <= '0;
      r_key_cached <= 1'b0;
    end else if (w_wd_abort) begin
      r_key_cached <= 1'b0;
    end else if ((r_state == ST_LOAD_KEY) && (r_cnt == KEY_LAST)) begin
      // Register has rotated KEY_W-1 times; one more rotation is the full key.
      r_key_cache  <= {w_key_par[0], w_key_par[KEY_W-1:1]};
      r_key_cached <= 1'b1;
    end
  end

  assign w_unused = ^{w_pt_par, w_ct_par[0], w_ct_ser};
`else
  assign w_key_hit = 1'b0;
  assign w_unused  = ^{w_pt_par, w_ct_par[0], w_ct_ser, w_key_par};
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = w_key_hit ? ST_LOAD_PT : ST_LOAD_KEY;
        end
      end
      ST_LOAD_KEY: begin
        if (r_cnt == KEY_LAST) begin
          w_state_next = ST_LOAD_PT;
        end
      end
      ST_LOAD_PT: begin
        if (r_cnt == PT_LAST) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (core_valid) begin
          w_state_next = ST_CAPTURE;
        end else if (w_wd_abort) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (w_cap_done) begin
          w_state_next = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from state
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready      = 1'b0;
    busy          = 1'b1;
    core_data_rdy = CMD_IDLE;
    core_data_in  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_LOAD_KEY: begin
        core_data_rdy = CMD_LOAD_KEY;
        core_data_in  = w_key_ser;
      end
      ST_LOAD_PT: begin
        core_data_rdy = CMD_LOAD_PT;
        core_data_in  = w_pt_ser;
      end
      ST_RUN, ST_CAPTURE: begin
        core_data_rdy = CMD_RUN;
      end
      default: begin
        core_data_rdy = CMD_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bit / capture counter. In CAPTURE it holds the number of bits already
  // taken, so it enters CAPTURE at 1 because RUN took bit 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if ((r_state == ST_RUN) && core_valid) begin
      r_cnt <= CNT_ONE;
    end else if (w_state_change) begin
      r_cnt <= '0;
    end else if ((r_state == ST_LOAD_KEY) || (r_state == ST_LOAD_PT) ||
                 ((r_state == ST_CAPTURE) && core_valid)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // RUN watchdog
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wd <= '0;
    end else if (w_state_change) begin
      r_wd <= '0;
    end else if (r_state == ST_RUN) begin
      r_wd <= r_wd + WD_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Result, handshake and error registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ct_out    <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_wd_abort;
      if (w_cap_done) begin
        // Take the shift register value including the bit arriving now.
        r_ct_out    <= {core_cipher_out, w_ct_par[BLOCK_W-1:1]};
        r_out_valid <= 1'b1;
      end else if ((r_state == ST_OUT) && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign ct_out    = r_ct_out;
  assign out_valid = r_out_valid;
  assign err       = r_err;

endmodule
